// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: slot occupancy state and drop counter sizing.
package stream_demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the demux input stream, per-channel output streams and drop status.
// master drives the input beat and sink readies; slave is the demux itself.
interface stream_demux_if
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 16
);
    localparam int SEL_W = $clog2(N_OUT);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   err_sel;
    logic [DROP_CNT_W-1:0]  drop_cnt;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, err_sel, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, err_sel, drop_cnt
    );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel; load to valid in 1 cycle.
// free_o is high when empty or draining this cycle, so load and drain may overlap.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             free_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Loads only arrive when free, so a FULL slot either refills or drains, never both stalled.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            EMPTY: begin
                if (load_i) begin
                    state_d = FULL;
                    data_d  = data_i;
                end
            end
            FULL: begin
                if (load_i) begin
                    data_d = data_i;
                end else if (ready_i) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    assign valid_o = (state_q == FULL);
    assign free_o  = (state_q == EMPTY) || ready_i;
    assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// Unicast/broadcast stream demux into N_OUT one-entry channels; 1-cycle accept-to-valid latency.
// in_ready follows the target channel(s) being free; broadcast waits for all, bad selects are dropped.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 16
) (
    input logic           clk,
    input logic           rst_n,
    stream_demux_if.slave bus
);

    localparam int SEL_W = $clog2(N_OUT);

    logic [N_OUT-1:0]       free;
    logic [N_OUT-1:0]       tgt_hot;
    logic [N_OUT-1:0]       load;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   sel_ok;
    logic                   in_ready;
    logic                   accept;
    logic                   drop;
    logic                   err_sel_q, err_sel_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // One extra bit so N_OUT itself is representable when it is a power of two.
    assign sel_ok = ({1'b0, bus.in_sel} < (SEL_W+1)'(N_OUT));

    always_comb begin
        tgt_hot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            tgt_hot[k] = bus.in_bcast || (bus.in_sel == SEL_W'(k));
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst_n) begin
            in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            in_ready = &free;
        end else if (!sel_ok) begin
            in_ready = 1'b1;
        end else begin
            in_ready = |(tgt_hot & free);
        end
    end

    assign accept = bus.in_valid && in_ready;
    assign load   = accept ? tgt_hot : '0;
    assign drop   = accept && !bus.in_bcast && !sel_ok;

    always_comb begin
        err_sel_d  = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .data_i  (bus.in_data),
            .ready_i (bus.out_ready[k]),
            .valid_o (out_valid[k]),
            .free_o  (free[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.err_sel   = err_sel_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 16-channel instance for the data path and a
// 12-channel instance for out-of-range selects and drop counter saturation.
module tb_stream_demux;
    import stream_demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(8), .N_OUT(16)) b16 ();
    stream_demux_if #(.WIDTH(8), .N_OUT(12)) b12 ();

    stream_demux #(.WIDTH(8), .N_OUT(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    stream_demux #(.WIDTH(8), .N_OUT(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

    typedef struct {
        logic        vld;
        logic        bc;
        logic [3:0]  sel;
        logic [7:0]  dat;
        logic [15:0] rdy;
        logic        exp_rdy;
        logic [15:0] exp_vld;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive16(input logic vld, input logic bc, input logic [3:0] sel,
                           input logic [7:0] dat, input logic [15:0] rdy);
        b16.in_valid  = vld;
        b16.in_bcast  = bc;
        b16.in_sel    = sel;
        b16.in_data   = dat;
        b16.out_ready = rdy;
    endtask

    task automatic drive12(input logic vld, input logic bc, input logic [3:0] sel,
                           input logic [7:0] dat);
        b12.in_valid  = vld;
        b12.in_bcast  = bc;
        b12.in_sel    = sel;
        b12.in_data   = dat;
        b12.out_ready = 12'hFFF;
    endtask

    initial begin
        // Unicast sweep, then broadcast, then a hold/release on channel 2.
        for (int s = 0; s < 16; s++) begin
            vecs.push_back('{1'b1, 1'b0, 4'(s), 8'hA5, 16'hFFFF, 1'b1, 16'(1 << s), 8'hA5});
        end
        vecs.push_back('{1'b1, 1'b1, 4'd9, 8'hC3, 16'hFFFF, 1'b1, 16'hFFFF, 8'hC3});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF, 1'b1, 16'h0000, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 8'h5A, 16'h0000, 1'b1, 16'h0004, 8'h5A});
        vecs.push_back('{1'b0, 1'b0, 4'd2, 8'hEE, 16'h0000, 1'b0, 16'h0004, 8'h5A});
        vecs.push_back('{1'b1, 1'b0, 4'd2, 8'hEE, 16'h0000, 1'b0, 16'h0004, 8'h5A});
        vecs.push_back('{1'b0, 1'b0, 4'd2, 8'h00, 16'hFFFF, 1'b1, 16'h0000, 8'h00});

        rst_n = 1'b0;
        drive16(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF);
        drive12(1'b0, 1'b0, 4'd13, 8'h00);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready16", b16.in_ready, 1'b0);
        chk("rst_in_ready12", b12.in_ready, 1'b0);
        chk("rst_out_valid", b16.out_valid, 16'h0);
        chk("rst_out_data", b16.out_data, 128'h0);
        chk("rst_err_sel", b12.err_sel, 1'b0);
        chk("rst_drop_cnt", b12.drop_cnt, 16'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive16(vecs[i].vld, vecs[i].bc, vecs[i].sel, vecs[i].dat, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_in_ready", i), b16.in_ready, vecs[i].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), b16.out_valid, vecs[i].exp_vld);
            for (int k = 0; k < 16; k++) begin
                if (vecs[i].exp_vld[k]) begin
                    chk($sformatf("v%0d_data_ch%0d", i, k), b16.out_data[k*8 +: 8], vecs[i].exp_dat);
                end
            end
        end

        // Backpressure on channel 3 must not block channel 4
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd3, 8'h11, 16'hFFF7);
        #1 chk("bp_first_ready", b16.in_ready, 1'b1);
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd3, 8'h22, 16'hFFF7);
        #1 chk("bp_second_ready", b16.in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_hold_valid", b16.out_valid, 16'h0008);
        chk("bp_hold_data", b16.out_data[3*8 +: 8], 8'h11);
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd4, 8'h44, 16'hFFF7);
        #1 chk("bp_ch4_ready", b16.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_ch4_valid", b16.out_valid, 16'h0018);
        chk("bp_ch4_data", b16.out_data[4*8 +: 8], 8'h44);
        chk("bp_ch3_stable", b16.out_data[3*8 +: 8], 8'h11);
        @(negedge clk);
        drive16(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF);
        @(posedge clk);
        #1 chk("bp_drained", b16.out_valid, 16'h0);

        // Broadcast is all-or-nothing while channel 7 is stalled
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd7, 8'h77, 16'hFF7F);
        @(negedge clk);
        drive16(1'b1, 1'b1, 4'd0, 8'h3C, 16'hFF7F);
        #1 chk("bc_blocked_ready", b16.in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("bc_blocked_valid", b16.out_valid, 16'h0080);
        chk("bc_blocked_ch7", b16.out_data[7*8 +: 8], 8'h77);
        @(negedge clk);
        drive16(1'b1, 1'b1, 4'd0, 8'h3C, 16'hFFFF);
        #1 chk("bc_release_ready", b16.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bc_all_valid", b16.out_valid, 16'hFFFF);
        chk("bc_all_data", b16.out_data, {16{8'h3C}});
        @(negedge clk);
        drive16(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF);
        @(posedge clk);
        #1 chk("bc_drained", b16.out_valid, 16'h0);

        // Back-to-back streaming into channel 5
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive16(1'b1, 1'b0, 4'd5, 8'(8'h50 + i), 16'hFFFF);
            #1 chk($sformatf("st%0d_ready", i), b16.in_ready, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("st%0d_valid", i), b16.out_valid, 16'h0020);
            chk($sformatf("st%0d_data", i), b16.out_data[5*8 +: 8], 8'(8'h50 + i));
        end
        @(negedge clk);
        drive16(1'b0, 1'b0, 4'd0, 8'h00, 16'hFFFF);

        // Out-of-range select on the 12-channel instance
        @(negedge clk);
        drive12(1'b1, 1'b0, 4'd13, 8'hD0);
        #1 chk("oor_ready", b12.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("oor_no_valid", b12.out_valid, 12'h0);
        chk("oor_err_sel", b12.err_sel, 1'b1);
        chk("oor_drop_cnt", b12.drop_cnt, 16'd1);
        @(negedge clk);
        drive12(1'b1, 1'b0, 4'd11, 8'hB1);
        #1 chk("u12_ready", b12.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("oor_err_clear", b12.err_sel, 1'b0);
        chk("u12_valid", b12.out_valid, 12'h800);
        chk("u12_data", b12.out_data[11*8 +: 8], 8'hB1);
        chk("u12_drop_cnt", b12.drop_cnt, 16'd1);
        @(negedge clk);
        drive12(1'b1, 1'b1, 4'd13, 8'h6E);
        #1 chk("bc12_ready", b12.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("bc12_valid", b12.out_valid, 12'hFFF);
        chk("bc12_drop_cnt", b12.drop_cnt, 16'd1);
        chk("bc12_err_sel", b12.err_sel, 1'b0);

        // Saturation: 65535 drops reach the ceiling, the 65536th stays there
        @(negedge clk);
        drive12(1'b1, 1'b0, 4'd13, 8'h00);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_65535", b12.drop_cnt, 16'hFFFF);
        chk("sat_err_sel", b12.err_sel, 1'b1);
        @(posedge clk);
        #1 chk("sat_65536", b12.drop_cnt, 16'hFFFF);
        @(negedge clk);
        drive12(1'b0, 1'b0, 4'd13, 8'h00);

        // Reset with channels 2 and 9 holding beats
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd2, 8'h22, 16'hFDFB);
        @(negedge clk);
        drive16(1'b1, 1'b0, 4'd9, 8'h99, 16'hFDFB);
        @(posedge clk);
        #1 chk("mr_loaded", b16.out_valid, 16'h0204);
        @(negedge clk);
        drive16(1'b0, 1'b0, 4'd0, 8'h00, 16'hFDFB);
        rst_n = 1'b0;
        #1;
        chk("mr_ready16", b16.in_ready, 1'b0);
        chk("mr_ready12", b12.in_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("mr_out_valid", b16.out_valid, 16'h0);
        chk("mr_out_data", b16.out_data, 128'h0);
        chk("mr_drop_cnt", b12.drop_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("mr_after_release", b16.out_valid, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload bits per beat.
REQ-002 SHALL have parameter N_OUT, default 16: output channel count, legal range 2..64.
REQ-003 SHALL derive localparam SEL_W = $clog2(N_OUT); it SHALL NOT be overridable.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  input beat accepted this cycle when in_valid=1.
REQ-009 in_data  input  WIDTH  payload.
REQ-010 in_sel  input  SEL_W  destination channel for unicast.
REQ-011 in_bcast  input  1  1 = deliver the beat to all N_OUT channels; in_sel is ignored.
REQ-012 out_valid  output  N_OUT  per-channel beat present.
REQ-013 out_ready  input  N_OUT  per-channel sink ready.
REQ-014 out_data  output  N_OUT*WIDTH  flattened payloads; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-015 err_sel  output  1  one-cycle pulse: a unicast beat with in_sel >= N_OUT was dropped.
REQ-016 drop_cnt  output  16  saturating count of dropped beats.

Function
REQ-017 Each channel SHALL hold a one-entry output register with two states: EMPTY and FULL; out_valid[k] = (state k == FULL).
REQ-018 Channel k SHALL be "free" when it is EMPTY, or when it is FULL with out_ready[k]=1 in the same cycle.
REQ-019 Unicast with in_sel < N_OUT: in_ready SHALL equal free[in_sel].
REQ-020 Broadcast: in_ready SHALL be 1 only when every channel is free; broadcasts SHALL be delivered all-or-nothing, never partially.
REQ-021 Unicast with in_sel >= N_OUT: in_ready SHALL be 1, the beat SHALL be discarded, and err_sel SHALL pulse in the following cycle.
REQ-022 drop_cnt SHALL increment by 1 on each discarded beat and SHALL saturate at 16'hFFFF.
REQ-023 On acceptance, each target channel SHALL load in_data and become FULL on the next edge; latency is exactly 1 cycle, from the input handshake to out_valid.
REQ-024 A FULL channel with out_ready=1 and no new load SHALL become EMPTY on the next edge.
REQ-025 Simultaneous drain and load on the same channel SHALL leave it FULL with the new data; sustained throughput SHALL be 1 beat per cycle per channel.
REQ-026 out_data[k] SHALL remain stable while out_valid[k]=1 and out_ready[k]=0.
REQ-027 in_ready SHALL depend combinationally only on in_sel, in_bcast, the channel states and out_ready; it SHALL NOT depend on in_valid.
REQ-028 Channels SHALL be independent: a stall on one channel SHALL NOT block unicast traffic to another channel.

Reset
REQ-029 When rst_n=0 at an edge, the block SHALL set all channels EMPTY, out_valid=0, out_data=0, err_sel=0 and drop_cnt=0.
REQ-030 Reset mid-transfer SHALL discard any held beats; no beat SHALL be presented after reset release until a new beat is accepted.
REQ-031 in_ready SHALL be 0 while rst_n=0.

Structure
REQ-032 A shared package SHALL hold the channel state enum (EMPTY/FULL) and the drop counter width constant (16).
REQ-033 The one-entry channel register SHALL be a sub-module, demux_slot (WIDTH-parametrised), instantiated N_OUT times via generate.
REQ-034 Target decode SHALL be a single for-loop one-hot decode gated by in_bcast.

Verification
REQ-035 Unicast sweep: WIDTH=8, N_OUT=16; send in_data=8'hA5 with in_sel=0..15, all out_ready=1 -> each beat appears one cycle later on only out_valid[sel], with out_data[sel]=8'hA5.
REQ-036 Backpressure: out_ready[3]=0; send two beats to channel 3 -> the first is held stable and in_ready=0 for the second; a beat to channel 4 in the same cycle is accepted.
REQ-037 Broadcast: data 8'h3C with out_ready[7]=0 and channel 7 FULL -> in_ready=0 and no channel loads; release out_ready[7] -> all 16 channels load 8'h3C one cycle after acceptance.
REQ-038 Out-of-range select: N_OUT=12, in_sel=13 -> in_ready=1, no out_valid, err_sel pulses 1 cycle, drop_cnt=1; 65536 drops -> drop_cnt=16'hFFFF.
REQ-039 Reset mid-operation: channels 2 and 9 FULL, assert rst_n=0 for one edge -> out_valid=0, drop_cnt=0, and in_ready=0 while rst_n=0.
REQ-040 Streaming: continuous in_valid to channel 5 with out_ready[5]=1 -> one beat per cycle with no bubbles and data in order.
